// File: rtl/cla_modaddsub_ctrl.sv
// cla_modaddsub_ctrl
// Sequencing controller for the single shared W-bit carry-lookahead adder used
// by the NTT butterfly add/sub lanes. Two requesters are served round-robin. Each
// granted request runs through the adder once or twice to form (a +/- b) mod q.
// The result is then returned over a valid/ready port, tagged with the requester id.
//
// Optional build macro: CLA_MODADDSUB_FASTSUB_EN
//   When defined, a subtract that does not borrow finishes after PASS1.
//   Its latency is then 2 instead of 3. Results are the same in both builds.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   in_valid[1:0]     per-requester request valid
//   in_ready[1:0]     per-requester accept; at most one bit set, only in IDLE
//   in_op[1:0]        per-requester op: 0 = modular add, 1 = modular subtract
//   in_a0, in_b0      requester 0 operands
//   in_a1, in_b1      requester 1 operands
//   mod_q             modulus, sampled at accept
//   out_valid         result valid (held until out_ready)
//   out_ready         downstream accept
//   out_data          result
//   out_id            requester that owns out_data
//   busy              high whenever the controller is not in IDLE
module cla_modaddsub_ctrl #(
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   in_valid,
  output logic [1:0]   in_ready,
  input  logic [1:0]   in_op,
  input  logic [W-1:0] in_a0,
  input  logic [W-1:0] in_b0,
  input  logic [W-1:0] in_a1,
  input  logic [W-1:0] in_b1,
  input  logic [W-1:0] mod_q,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_id,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

  state_t         state;
  logic           rr_ptr;
  logic [W-1:0]   a_reg, b_reg, q_reg, s_reg;
  logic           op_reg, c1_reg;

  logic [1:0]     grant;
  logic           sel_id;

  // Shared adder signals
  logic [W-1:0]   add_x, add_y, add_p, add_g, add_sum;
  logic           add_cin, add_cout;
  logic [W-1:0]   pass2_result;

  // Round-robin grant. It is only offered in IDLE and is always one-hot.
  always_comb begin
    grant = 2'b00;
    if (state == IDLE) begin
      case (in_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = rr_ptr ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  // While reset is held, no requester may be told it was accepted.
  assign in_ready = rst ? 2'b00 : grant;
  assign sel_id   = grant[1];
  assign busy     = (state != IDLE);

  // Adder operand selection.
  // PASS1 forms a + b, or a + ~b + 1 for a subtract.
  // PASS2 forms s + ~q + 1 (add) or s + q (subtract).
  always_comb begin
    add_x   = a_reg;
    add_y   = op_reg ? ~b_reg : b_reg;
    add_cin = op_reg;
    if (state == PASS2) begin
      add_x   = s_reg;
      add_y   = op_reg ? q_reg : ~q_reg;
      add_cin = ~op_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_pg
      assign add_p[gi] = add_x[gi] ^ add_y[gi];
      assign add_g[gi] = add_x[gi] & add_y[gi];
    end
  endgenerate

  // Carry chain built from generate/propagate terms: c[i+1] = g[i] | p[i]&c[i]
  always_comb begin
    logic c;
    c       = add_cin;
    add_sum = '0;
    for (int i = 0; i < W; i++) begin
      add_sum[i] = add_p[i] ^ c;
      c          = add_g[i] | (add_p[i] & c);
    end
    add_cout = c;
  end

  // Add: take s - q if the first pass overflowed (c1) or s >= q (c2).
  // Sub: keep a - b if there was no borrow (c1), otherwise wrap by adding q.
  always_comb begin
    if (op_reg)
      pass2_result = c1_reg ? s_reg : add_sum;
    else
      pass2_result = (c1_reg | add_cout) ? add_sum : s_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      q_reg     <= '0;
      s_reg     <= '0;
      op_reg    <= 1'b0;
      c1_reg    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant != 2'b00) begin
            a_reg  <= sel_id ? in_a1 : in_a0;
            b_reg  <= sel_id ? in_b1 : in_b0;
            op_reg <= in_op[sel_id];
            q_reg  <= mod_q;
            // out_id is not qualified until out_valid, so it can be loaded now.
            out_id <= sel_id;
            rr_ptr <= ~sel_id;
            state  <= PASS1;
          end
        end
        PASS1: begin
          s_reg  <= add_sum;
          c1_reg <= add_cout;
`ifdef CLA_MODADDSUB_FASTSUB_EN
          if (op_reg && add_cout) begin
            out_data  <= add_sum;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            state <= PASS2;
          end
`else
          state <= PASS2;
`endif
        end
        PASS2: begin
          out_data  <= pass2_result;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_modaddsub_ctrl.sv
// Testbench for cla_modaddsub_ctrl.
// The stimulus process issues requests and pushes the expected result into a
// scoreboard queue at accept time. A separate monitor checks every cycle.
// It checks in_ready and busy against an arbitration model. It also pops and
// compares each output, including its latency.
// The bench follows CLA_MODADDSUB_FASTSUB_EN when computing expected latency.
module tb_cla_modaddsub_ctrl;
  localparam int W = 128;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   in_valid;
  logic [1:0]   in_ready;
  logic [1:0]   in_op;
  logic [W-1:0] in_a0, in_b0, in_a1, in_b1, mod_q;
  logic         out_valid, out_ready, out_id, busy;
  logic [W-1:0] out_data;

  cla_modaddsub_ctrl #(.W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a0(in_a0), .in_b0(in_b0), .in_a1(in_a1), .in_b1(in_b1), .mod_q(mod_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_id(out_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic op; logic [W-1:0] a; logic [W-1:0] b; } req_t;
  typedef struct { logic [W-1:0] data; logic id; int lat; int acc; } exp_t;

  req_t rq0[$];
  req_t rq1[$];
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic or_rand = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Reference: (a + b) reduced once by q, or (a - b) wrapped by q on borrow.
  function automatic logic [W-1:0] ref_model(logic op, logic [W-1:0] a,
                                             logic [W-1:0] b, logic [W-1:0] q);
    logic [W:0] full;
    if (!op) begin
      full = {1'b0, a} + {1'b0, b};
      if (full >= {1'b0, q}) full = full - {1'b0, q};
      return full[W-1:0];
    end else begin
      if (a >= b) return a - b;
      return a - b + q;
    end
  endfunction

  function automatic int ref_latency(logic op, logic [W-1:0] a, logic [W-1:0] b);
`ifdef CLA_MODADDSUB_FASTSUB_EN
    if (op && (a >= b)) return 2;
`endif
    return 3;
  endfunction

  function automatic logic [1:0] grant_model(logic [1:0] v, logic rr);
    if (v == 2'b11) return rr ? 2'b10 : 2'b01;
    return v;
  endfunction

  function automatic void push_exp(logic id, req_t r);
    exp_t e;
    e.data = ref_model(r.op, r.a, r.b, mod_q);
    e.id   = id;
    e.lat  = ref_latency(r.op, r.a, r.b);
    e.acc  = cyc;
    exp_q.push_back(e);
  endfunction

  // Stimulus driver: present queued requests; scramble idle operand lines.
  initial begin
    logic [1:0] tk;
    in_valid = 2'b00; in_op = 2'b00;
    in_a0 = '0; in_b0 = '0; in_a1 = '0; in_b1 = '0;
    forever begin
      @(negedge clk);
      tk = 2'b00;
      if (!rst) begin
        if (in_valid[0] && in_ready[0] && rq0.size() > 0) begin tk[0] = 1'b1; push_exp(1'b0, rq0[0]); end
        if (in_valid[1] && in_ready[1] && rq1.size() > 0) begin tk[1] = 1'b1; push_exp(1'b1, rq1[0]); end
      end
      @(posedge clk); #1;
      if (tk[0]) void'(rq0.pop_front());
      if (tk[1]) void'(rq1.pop_front());
      if (rq0.size() > 0) begin
        in_valid[0] = 1'b1; in_op[0] = rq0[0].op; in_a0 = rq0[0].a; in_b0 = rq0[0].b;
      end else begin
        in_valid[0] = 1'b0; in_op[0] = 1'($urandom_range(0, 1)); in_a0 = rand128(); in_b0 = rand128();
      end
      if (rq1.size() > 0) begin
        in_valid[1] = 1'b1; in_op[1] = rq1[0].op; in_a1 = rq1[0].a; in_b1 = rq1[0].b;
      end else begin
        in_valid[1] = 1'b0; in_op[1] = 1'($urandom_range(0, 1)); in_a1 = rand128(); in_b1 = rand128();
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (or_rand) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: arbitration/busy model plus scoreboard compare of outputs.
  initial begin
    logic       rr_m, busy_m, prev_ov;
    logic [1:0] exp_rdy;
    exp_t       e;
    rr_m = 1'b0; busy_m = 1'b0; prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        n_cmp++;
        if (in_ready !== 2'b00 || out_valid !== 1'b0 || busy !== 1'b0 ||
            out_data !== '0 || out_id !== 1'b0) begin
          n_bad++;
          $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b out_id=%b out_data=%h, required all zero",
                   in_ready, out_valid, busy, out_id, out_data);
        end
        rr_m = 1'b0; busy_m = 1'b0; prev_ov = 1'b0;
      end else begin
        exp_rdy = busy_m ? 2'b00 : grant_model(in_valid, rr_m);
        n_cmp++;
        if (in_ready !== exp_rdy || busy !== busy_m) begin
          n_bad++;
          $display("FAIL ctrl cyc %0d: in_ready=%b busy=%b, required in_ready=%b busy=%b",
                   cyc, in_ready, busy, exp_rdy, busy_m);
        end
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL spurious_out cyc %0d: out_valid=1 id=%b data=%h, required no output", cyc, out_id, out_data);
          end else begin
            e = exp_q[0];
            n_cmp++;
            if (out_data !== e.data || out_id !== e.id) begin
              n_bad++;
              $display("FAIL result cyc %0d: id=%b data=%h, required id=%b data=%h",
                       cyc, out_id, out_data, e.id, e.data);
            end
            if (!prev_ov) begin
              n_cmp++;
              if (cyc - e.acc != e.lat) begin
                n_bad++;
                $display("FAIL latency: got %0d, required %0d", cyc - e.acc, e.lat);
              end
            end
            if (out_ready) void'(exp_q.pop_front());
          end
        end
        if (exp_rdy != 2'b00) begin busy_m = 1'b1; rr_m = ~exp_rdy[1]; end
        if (out_valid && out_ready) busy_m = 1'b0;
        prev_ov = out_valid;
      end
    end
  end

  task automatic wait_drain(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(posedge clk); #1;
      if (rq0.size() == 0 && rq1.size() == 0 && exp_q.size() == 0 && !busy) ok = 1'b1;
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_%s: pending req=%0d/%0d results=%0d, required 0", name, rq0.size(), rq1.size(), exp_q.size());
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1; rst = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    req_t r;
    logic [W-1:0] q;
    rst = 1'b1; out_ready = 1'b1; mod_q = 17;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Directed: add wrap, sub borrow, sub no borrow
    rq0.push_back('{1'b0, 128'd10, 128'd12}); wait_drain("add_wrap");
    rq1.push_back('{1'b1, 128'd3, 128'd9});   wait_drain("sub_borrow");
    rq0.push_back('{1'b1, 128'd9, 128'd3});   wait_drain("sub_noborrow");

    // Arbitration: both requesters continuously valid from reset
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      rq0.push_back('{1'b0, 128'd1, 128'd1});
      rq1.push_back('{1'b0, 128'd2, 128'd2});
    end
    wait_drain("arbitration");

    // Backpressure: hold out_ready low for 10 cycles with another request pending
    out_ready = 1'b0;
    rq0.push_back('{1'b0, 128'd5, 128'd6});
    for (int i = 0; i < 20 && !out_valid; i++) begin @(posedge clk); #1; end
    rq1.push_back('{1'b1, 128'd7, 128'd2});
    repeat (10) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_drain("backpressure");

    // Reset during PASS1: in-flight op is discarded, rr_ptr returns to 0
    rq0.push_back('{1'b0, 128'd3, 128'd4});
    for (int i = 0; i < 20 && !busy; i++) begin @(posedge clk); #1; end
    rst = 1'b1;
    exp_q.delete();
    rq0.push_back('{1'b0, 128'd16, 128'd16});
    rq1.push_back('{1'b0, 128'd5, 128'd5});
    @(posedge clk); #1 rst = 1'b0;
    wait_drain("reset_midop");

    // Randomized batches with random gaps and random backpressure
    or_rand = 1'b1;
    for (int bt = 0; bt < 4; bt++) begin
      case (bt)
        0: q = 128'd17;
        1: q = rand128() | 128'd1;
        2: q = {96'd0, $urandom()} | 128'd1;
        default: q = ~128'd0;
      endcase
      mod_q = q;
      for (int n = 0; n < 15; n++) begin
        r.op = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) begin
          r.a = rand128(); r.b = rand128();
        end else begin
          r.a = rand128() % q; r.b = rand128() % q;
        end
        if ($urandom_range(0, 1) == 0) rq0.push_back(r); else rq1.push_back(r);
        repeat ($urandom_range(0, 5)) @(posedge clk);
        #1;
      end
      wait_drain("random");
    end
    or_rand = 1'b0;
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
